// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit and the datapath it drives:
// state codes, opcode/funct constants, select encodings and the instruction class vector.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;

  localparam logic [2:0] DST_RT   = 3'd0;
  localparam logic [2:0] DST_RD   = 3'd1;
  localparam logic [2:0] DST_RA   = 3'd2;

  localparam logic [2:0] SRC_RT   = 3'd0;
  localparam logic [2:0] SRC_IMM  = 3'd1;

  localparam logic [2:0] TOREG_ALU = 3'd0;
  localparam logic [2:0] TOREG_DM  = 3'd1;
  localparam logic [2:0] TOREG_PC4 = 3'd2;

  // One-hot instruction class; exactly one field is set for any Op/Func pair.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic unknown;
  } insn_class_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] alu_src_sel;
    logic [2:0] ext_op;
  } alu_ctrl_t;

  // ALU/operand selects used in EXEC and held through MEM for the address.
  function automatic alu_ctrl_t alu_ctrl(input insn_class_t c);
    alu_ctrl_t r;
    r = '{alu_op: ALU_ADD, alu_src_sel: SRC_RT, ext_op: EXT_ZERO};
    if (c.subu || c.beq) r.alu_op = ALU_SUB;
    if (c.ori) begin
      r.alu_op      = ALU_OR;
      r.alu_src_sel = SRC_IMM;
    end
    if (c.lui) begin
      r.alu_op      = ALU_LUI;
      r.alu_src_sel = SRC_IMM;
    end
    if (c.lw || c.sw) begin
      r.alu_src_sel = SRC_IMM;
      r.ext_op      = EXT_SIGN;
    end
    if (c.beq) r.ext_op = EXT_SIGN;
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational classifier: maps the IR opcode/funct fields to a one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  output insn_class_t cls
);

  always_comb begin
    // NOTE: default every field before the case so no path leaves cls unassigned (no latch).
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls.addu    = 1'b1;
          FN_SUBU: cls.subu    = 1'b1;
          FN_JR:   cls.jr      = 1'b1;
          FN_NOP:  cls.nop     = 1'b1;
          default: cls.unknown = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control unit: steps the datapath through FETCH/DECODE/EXEC/MEM/WB,
// issuing register enables, memory requests and one retire pulse per instruction.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic [2:0] RegDstSel,
  output logic [2:0] ALUSrcSel,
  output logic [2:0] toRegSel,
  output logic [2:0] NPCOp,
  output logic [3:0] ALUOp,
  output logic [2:0] EXTOp,
  output logic       retire,
  output logic       mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  insn_class_t        cls;
  alu_ctrl_t          alu;
  logic               short_insn;
  logic               timed_out;

  mc_decode u_decode (
    .op   (Op),
    .func (Func),
    .cls  (cls)
  );

  assign alu        = alu_ctrl(cls);
  // Instructions that finish in DECODE: jumps, nop and anything unrecognised.
  assign short_insn = cls.j | cls.jal | cls.jr | cls.nop | cls.unknown;
  assign timed_out  = (MEM_TIMEOUT > 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
  assign mem_err    = mem_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      mem_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      mem_err_q  <= mem_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_err_d  = mem_err_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = short_insn ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (cls.lw || cls.sw) state_d = S_MEM;
        else if (cls.beq)     state_d = S_FETCH;
        else                  state_d = S_WB;
      end
      S_MEM: begin
        if (timed_out) begin
          state_d   = S_FETCH;
          mem_err_d = 1'b1;
        end else if (dmem_ready) begin
          state_d = cls.lw ? S_WB : S_FETCH;
        end else if (MEM_TIMEOUT > 0) begin
          // Counter only advances while stalled in MEM; any exit clears it.
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    retire    = 1'b0;
    RegDstSel = DST_RT;
    ALUSrcSel = SRC_RT;
    toRegSel  = TOREG_ALU;
    NPCOp     = NPC_PC4;
    ALUOp     = ALU_ADD;
    EXTOp     = EXT_ZERO;
    case (state_q)
      S_FETCH: begin
        IRWrite = imem_ready;
        PCWrite = imem_ready;
      end
      S_DECODE: begin
        retire = short_insn;
        if (cls.j || cls.jal) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_J;
        end
        if (cls.jal) begin
          RegWrite  = 1'b1;
          RegDstSel = DST_RA;
          toRegSel  = TOREG_PC4;
        end
        if (cls.jr) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JR;
        end
      end
      S_EXEC: begin
        ALUOp     = alu.alu_op;
        ALUSrcSel = alu.alu_src_sel;
        EXTOp     = alu.ext_op;
        if (cls.beq) begin
          NPCOp   = NPC_BEQ;
          PCWrite = Zero;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        ALUOp     = alu.alu_op;
        ALUSrcSel = alu.alu_src_sel;
        EXTOp     = alu.ext_op;
        if (timed_out) begin
          retire = 1'b1;
        end else begin
          MemRead  = cls.lw;
          MemWrite = cls.sw;
          retire   = cls.sw & dmem_ready;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        if (cls.addu || cls.subu) RegDstSel = DST_RD;
        if (cls.lw)               toRegSel  = TOREG_DM;
      end
      default: ;
    endcase
    // Reset is asynchronous, so gate every output directly rather than waiting on state.
    if (!reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      retire    = 1'b0;
      RegDstSel = '0;
      ALUSrcSel = '0;
      toRegSel  = '0;
      NPCOp     = '0;
      ALUOp     = '0;
      EXTOp     = '0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle enable/select/mem_err vectors for each
// instruction class, reset mid-access, FETCH stall and the MEM timeout path.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire, mem_err;
  logic [2:0] RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp;
  logic [3:0] ALUOp;

  int errors = 0;
  int checks = 0;
  int retire_cnt = 0;

  // Enable vector layout: {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire}
  localparam logic [5:0] EN_NONE   = 6'b000000;
  localparam logic [5:0] EN_FETCH  = 6'b110000;
  localparam logic [5:0] EN_WB     = 6'b001001;
  localparam logic [5:0] EN_RET    = 6'b000001;
  localparam logic [5:0] EN_RD     = 6'b000010;
  localparam logic [5:0] EN_WR     = 6'b000100;
  localparam logic [5:0] EN_SWDONE = 6'b000101;
  localparam logic [5:0] EN_JMP    = 6'b100001;
  localparam logic [5:0] EN_JAL    = 6'b101001;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_ORI  = 32'h3422_0005;
  localparam logic [31:0] I_LUI  = 32'h3C02_0001;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  wire [5:0]  en_obs  = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire};
  wire [18:0] sel_obs = {RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp};

  mc_control #(.MEM_TIMEOUT(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Func       (Func),
    .Zero       (Zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .RegDstSel  (RegDstSel),
    .ALUSrcSel  (ALUSrcSel),
    .toRegSel   (toRegSel),
    .NPCOp      (NPCOp),
    .ALUOp      (ALUOp),
    .EXTOp      (EXTOp),
    .retire     (retire),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (retire === 1'b1) retire_cnt++;

  // Selects packed as {RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp}.
  function automatic logic [18:0] sv(input int rd, input int src, input int tr,
                                     input int npc, input int alu, input int ext);
    return {3'(rd), 3'(src), 3'(tr), 3'(npc), 4'(alu), 3'(ext)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ir(input logic [31:0] ir);
    Op   = ir[31:26];
    Func = ir[5:0];
  endtask

  // Check one cycle at the falling edge, then step to just past the next rising edge.
  task automatic cyc(input string tag, input logic [5:0] en, input logic [18:0] sel,
                     input logic err);
    @(negedge clk);
    check({tag, ".en"},  32'(en_obs),  32'(en));
    check({tag, ".sel"}, 32'(sel_obs), 32'(sel));
    check({tag, ".err"}, 32'(mem_err), 32'(err));
    @(posedge clk);
    #1;
  endtask

  localparam logic [18:0] SEL0 = 19'd0;

  initial begin
    logic [18:0] sel_mem;
    sel_mem    = sv(0, 1, 0, 0, 0, 1);
    reset      = 1'b1;
    Zero       = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    set_ir(I_NOP);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_a", EN_NONE, SEL0, 1'b0);
    cyc("rst_b", EN_NONE, SEL0, 1'b0);

    // lw interrupted by reset while stalled in MEM
    reset = 1'b1;
    set_ir(I_LW);
    dmem_ready = 1'b0;
    cyc("lw0_f", EN_FETCH, SEL0, 1'b0);
    cyc("lw0_d", EN_NONE, SEL0, 1'b0);
    cyc("lw0_e", EN_NONE, sel_mem, 1'b0);
    cyc("lw0_m", EN_RD, sel_mem, 1'b0);
    reset = 1'b0;
    cyc("rmid_0", EN_NONE, SEL0, 1'b0);
    cyc("rmid_1", EN_NONE, SEL0, 1'b0);
    cyc("rmid_2", EN_NONE, SEL0, 1'b0);
    reset      = 1'b1;
    dmem_ready = 1'b1;
    set_ir(I_NOP);
    cyc("rel_f", EN_FETCH, SEL0, 1'b0);
    cyc("nop_d", EN_RET, SEL0, 1'b0);

    // FETCH stall, then addu
    imem_ready = 1'b0;
    set_ir(I_ADDU);
    cyc("stall_f", EN_NONE, SEL0, 1'b0);
    imem_ready = 1'b1;
    cyc("addu_f", EN_FETCH, SEL0, 1'b0);
    cyc("addu_d", EN_NONE, SEL0, 1'b0);
    cyc("addu_e", EN_NONE, sv(0, 0, 0, 0, 0, 0), 1'b0);
    cyc("addu_w", EN_WB, sv(1, 0, 0, 0, 0, 0), 1'b0);

    set_ir(I_SUBU);
    cyc("subu_f", EN_FETCH, SEL0, 1'b0);
    cyc("subu_d", EN_NONE, SEL0, 1'b0);
    cyc("subu_e", EN_NONE, sv(0, 0, 0, 0, 1, 0), 1'b0);
    cyc("subu_w", EN_WB, sv(1, 0, 0, 0, 0, 0), 1'b0);

    set_ir(I_ORI);
    cyc("ori_f", EN_FETCH, SEL0, 1'b0);
    cyc("ori_d", EN_NONE, SEL0, 1'b0);
    cyc("ori_e", EN_NONE, sv(0, 1, 0, 0, 2, 0), 1'b0);
    cyc("ori_w", EN_WB, SEL0, 1'b0);

    set_ir(I_LUI);
    cyc("lui_f", EN_FETCH, SEL0, 1'b0);
    cyc("lui_d", EN_NONE, SEL0, 1'b0);
    cyc("lui_e", EN_NONE, sv(0, 1, 0, 0, 3, 0), 1'b0);
    cyc("lui_w", EN_WB, SEL0, 1'b0);

    // lw with three stalled MEM cycles: 8 cycles total
    set_ir(I_LW);
    dmem_ready = 1'b0;
    cyc("lw_f", EN_FETCH, SEL0, 1'b0);
    cyc("lw_d", EN_NONE, SEL0, 1'b0);
    cyc("lw_e", EN_NONE, sel_mem, 1'b0);
    cyc("lw_m0", EN_RD, sel_mem, 1'b0);
    cyc("lw_m1", EN_RD, sel_mem, 1'b0);
    cyc("lw_m2", EN_RD, sel_mem, 1'b0);
    dmem_ready = 1'b1;
    cyc("lw_m3", EN_RD, sel_mem, 1'b0);
    cyc("lw_w", EN_WB, sv(0, 0, 1, 0, 0, 0), 1'b0);

    // beq taken then not taken
    set_ir(I_BEQ);
    Zero = 1'b1;
    cyc("beq1_f", EN_FETCH, SEL0, 1'b0);
    cyc("beq1_d", EN_NONE, SEL0, 1'b0);
    cyc("beq1_e", EN_JMP, sv(0, 0, 0, 1, 1, 1), 1'b0);
    Zero = 1'b0;
    cyc("beq0_f", EN_FETCH, SEL0, 1'b0);
    cyc("beq0_d", EN_NONE, SEL0, 1'b0);
    cyc("beq0_e", EN_RET, sv(0, 0, 0, 1, 1, 1), 1'b0);

    // Two-cycle instructions
    set_ir(I_JAL);
    cyc("jal_f", EN_FETCH, SEL0, 1'b0);
    cyc("jal_d", EN_JAL, sv(2, 0, 2, 2, 0, 0), 1'b0);
    set_ir(I_J);
    cyc("j_f", EN_FETCH, SEL0, 1'b0);
    cyc("j_d", EN_JMP, sv(0, 0, 0, 2, 0, 0), 1'b0);
    set_ir(I_JR);
    cyc("jr_f", EN_FETCH, SEL0, 1'b0);
    cyc("jr_d", EN_JMP, sv(0, 0, 0, 3, 0, 0), 1'b0);
    set_ir(I_BAD);
    cyc("bad_f", EN_FETCH, SEL0, 1'b0);
    cyc("bad_d", EN_RET, SEL0, 1'b0);

    // sw times out after 4 stalled MEM cycles
    set_ir(I_SW);
    dmem_ready = 1'b0;
    cyc("swto_f", EN_FETCH, SEL0, 1'b0);
    cyc("swto_d", EN_NONE, SEL0, 1'b0);
    cyc("swto_e", EN_NONE, sel_mem, 1'b0);
    cyc("swto_m0", EN_WR, sel_mem, 1'b0);
    cyc("swto_m1", EN_WR, sel_mem, 1'b0);
    cyc("swto_m2", EN_WR, sel_mem, 1'b0);
    cyc("swto_m3", EN_WR, sel_mem, 1'b0);
    cyc("swto_m4", EN_RET, sel_mem, 1'b0);

    // Following sw completes normally; mem_err stays set
    dmem_ready = 1'b1;
    cyc("sw_f", EN_FETCH, SEL0, 1'b1);
    cyc("sw_d", EN_NONE, SEL0, 1'b1);
    cyc("sw_e", EN_NONE, sel_mem, 1'b1);
    cyc("sw_m", EN_SWDONE, sel_mem, 1'b1);
    cyc("post_f", EN_FETCH, SEL0, 1'b1);

    check("retire_count", 32'(retire_cnt), 32'd14);

    reset = 1'b0;
    cyc("rst_err", EN_NONE, SEL0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
